mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single Memory32x8 instance between a loader port (port 0: fills and patches the sorted table) and the binary-search datapath (port 1: read-only lookups). It owns the memory's Address, DataIn and Write inputs and routes DataOut back with a per-port read-valid strobe. Ownership is round-robin with a bounded burst length, so a long table load cannot starve the search engine.

## Interface
- ADDR_W, 5, memory address width (32 words)
- DATA_W, 8, memory data width
- MAX_BURST, 4, max consecutive transactions by one owner while the other port is requesting (≥1)
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Req0 / Req1  in  1  port requests access; held until transactions complete
- Wr0  in  1  port 0 transaction is a write (port 1 is always read)
- Addr0 / Addr1  in  ADDR_W  transaction address
- WData0  in  DATA_W  port 0 write data
- Gnt0 / Gnt1  out  1  port currently owns the memory (registered)
- RValid0 / RValid1  out  1  read data for that port present on RData this cycle
- RData  out  DATA_W  shared read data, equals Mem_DataOut
- Mem_Addr  out  ADDR_W  to Memory32x8 Address
- Mem_DataIn  out  DATA_W  to Memory32x8 DataIn
- Mem_Write  out  1  to Memory32x8 Write
- Mem_DataOut  in  DATA_W  from Memory32x8 DataOut (valid one cycle after its address)

## Operation
- FSM states: IDLE, OWN0, OWN1. Gnt0 = (state==OWN0), Gnt1 = (state==OWN1).
- Transaction occurs in every cycle with Gnt_i & Req_i; Mem_Addr/Mem_DataIn/Mem_Write driven combinationally from owner's inputs; Mem_Write = Gnt0 & Req0 & Wr0.
- No owner or owner not requesting: Mem_Addr=0, Mem_DataIn=0, Mem_Write=0.
- IDLE: one Req → OWN of that port; both → port not in `last` flag (last = last port granted; reset value 1, so port 0 wins first tie).
- OWN_i, Req_i low: other requesting → OWN_other, else IDLE. Burst count cleared.
- OWN_i: burst count increments per transaction; on the transaction making count == MAX_BURST: other requesting → OWN_other next cycle, count cleared; otherwise count cleared and ownership retained.
- Reads: a granted read (port 1, or port 0 with Wr0=0) sets RValid_i the following cycle; RData = Mem_DataOut unconditionally.
- Reset values: state IDLE, Gnt0=Gnt1=0, RValid0=RValid1=0, count 0, last=1; Mem_* outputs 0. Reset during a read in flight suppresses its RValid.

## Timing
- Request-to-grant: Req sampled at edge N, Gnt high from cycle N+1; first transaction in cycle N+1.
- Read latency: address in cycle K, RValid and RData valid in cycle K+1; back-to-back reads give one result per cycle.
- Handover: last transaction of old owner in cycle K, new owner's Gnt and first transaction in cycle K+1; no idle bubble, no overlap.
- Write takes effect at end of granted cycle; a port 1 read of same address in the next cycle returns the new value.
- Gnt dropping with Req still high means preempted: requester holds Req/Addr/WData unchanged until regranted.

## Structure
- Shared package: FSM state enum (IDLE, OWN0, OWN1), ADDR_W/DATA_W defaults, MAX_BURST default.
- Sub-module arb_burst_counter: count register, clear/increment, terminal flag at MAX_BURST; width $clog2(MAX_BURST+1).
- Top-level binary_search integration: Control's M drives Addr1, Found/Less_Or_Greather logic consumes RData gated by RValid1.

## Test plan
- Reset: Reset held 2 cycles mid-stream → all Gnt/RValid/Mem_Write 0, next tie grants port 0.
- Single load: Req0, Wr0=1, Addr0=5, WData0=0x3C → Gnt0 next cycle, Mem_Write=1 with Mem_Addr=5, Mem_DataIn=0x3C; then port 1 reads addr 5 → RValid1 with RData=0x3C one cycle after its grant.
- Tie: Req0 and Req1 rise together from reset → Gnt0 first; with MAX_BURST=4 and both held, grant alternates every 4 cycles (0,0,0,0,1,1,1,1,0…).
- Uncontended burst: only Req0 for 10 cycles → Gnt0 stays high all 10, no gaps.
- Read pipeline: port 1 reads addresses 0..3 back to back → RValid1 high 4 consecutive cycles returning mem[0..3] in order; RValid0 stays 0.
- Early release: Req1 drops after 2 transactions while Req0 waiting → Gnt0 asserted the next cycle, count restarts at 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizing for the Memory32x8 two-port arbiter.
package mem_arbiter_pkg;
   localparam int ADDR_W_DEF    = 5;
   localparam int DATA_W_DEF    = 8;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;
endpackage

// File: rtl/arb_burst_counter.sv
// Counts consecutive transactions of the current owner; terminal flags the one that reaches MAX_BURST.
module arb_burst_counter #(
   parameter int MAX_BURST = 4,
   localparam int CW = $clog2(MAX_BURST + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic terminal
);
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

   logic [CW-1:0] count;

   assign terminal = inc && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin, burst-bounded arbiter giving the loader (port 0) and the search engine (port 1)
// shared access to Memory32x8.
//
// state | meaning
// IDLE  | no owner; next request (tie -> port not in last) takes the memory
// OWN0  | loader owns the memory; Gnt0 high
// OWN1  | search engine owns the memory; Gnt1 high
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              Wr0,
   input  logic [ADDR_W-1:0] Addr0,
   input  logic [ADDR_W-1:0] Addr1,
   input  logic [DATA_W-1:0] WData0,
   output logic              Gnt0,
   output logic              Gnt1,
   output logic              RValid0,
   output logic              RValid1,
   output logic [DATA_W-1:0] RData,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] Mem_DataIn,
   output logic              Mem_Write,
   input  logic [DATA_W-1:0] Mem_DataOut
);
   arb_state_e state;
   logic       last;
   logic       rvalid0;
   logic       rvalid1;
   logic       xact0;
   logic       xact1;
   logic       term;

   // Gating with Reset keeps the memory untouched while the arbiter is being reset.
   assign xact0 = !Reset && (state == OWN0) && Req0;
   assign xact1 = !Reset && (state == OWN1) && Req1;

   assign Gnt0    = (state == OWN0);
   assign Gnt1    = (state == OWN1);
   assign RValid0 = rvalid0;
   assign RValid1 = rvalid1;
   assign RData   = Mem_DataOut;

   arb_burst_counter #(.MAX_BURST(MAX_BURST)) u_burst (
      .clk      (Clock),
      .rst      (Reset),
      .clr      (!(xact0 || xact1) || term),
      .inc      (xact0 || xact1),
      .terminal (term)
   );

   always_comb begin
      Mem_Addr   = '0;
      Mem_DataIn = '0;
      Mem_Write  = 1'b0;
      if (xact0) begin
         Mem_Addr   = Addr0;
         Mem_DataIn = WData0;
         Mem_Write  = Wr0;
      end else if (xact1) begin
         Mem_Addr = Addr1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state   <= IDLE;
         last    <= 1'b1;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= xact0 && !Wr0;
         rvalid1 <= xact1;
         unique case (state)
            IDLE: begin
               if (Req0 && (!Req1 || last)) begin
                  state <= OWN0;
                  last  <= 1'b0;
               end else if (Req1) begin
                  state <= OWN1;
                  last  <= 1'b1;
               end
            end
            OWN0: begin
               // Burst end with no competitor keeps ownership; the counter restarts on its own.
               if (!Req0 || term) begin
                  if (Req1) begin
                     state <= OWN1;
                     last  <= 1'b1;
                  end else if (!Req0) begin
                     state <= IDLE;
                  end
               end
            end
            OWN1: begin
               if (!Req1 || term) begin
                  if (Req0) begin
                     state <= OWN0;
                     last  <= 1'b0;
                  end else if (!Req1) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural Memory32x8 and a read-data scoreboard.
module tb_mem_arbiter;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam int MB = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Req0, Req1, Wr0;
   logic [AW-1:0] Addr0, Addr1;
   logic [DW-1:0] WData0;
   logic          Gnt0, Gnt1, RValid0, RValid1;
   logic [DW-1:0] RData;
   logic [AW-1:0] Mem_Addr;
   logic [DW-1:0] Mem_DataIn;
   logic          Mem_Write;
   logic [DW-1:0] Mem_DataOut;

   logic [DW-1:0] mem     [32];
   logic [DW-1:0] ref_mem [32];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clock = ~Clock;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .Req0        (Req0),
      .Req1        (Req1),
      .Wr0         (Wr0),
      .Addr0       (Addr0),
      .Addr1       (Addr1),
      .WData0      (WData0),
      .Gnt0        (Gnt0),
      .Gnt1        (Gnt1),
      .RValid0     (RValid0),
      .RValid1     (RValid1),
      .RData       (RData),
      .Mem_Addr    (Mem_Addr),
      .Mem_DataIn  (Mem_DataIn),
      .Mem_Write   (Mem_Write),
      .Mem_DataOut (Mem_DataOut)
   );

   // Memory32x8: synchronous write, registered read of the presented address.
   always @(posedge Clock) begin
      if (Mem_Write) mem[Mem_Addr] <= Mem_DataIn;
      Mem_DataOut <= mem[Mem_Addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Scoreboard: results popped before this cycle's transactions are pushed.
   always @(negedge Clock) begin
      if (Reset) begin
         q0.delete();
         q1.delete();
      end else begin
         chk("gnt_overlap", 32'(Gnt0 & Gnt1), 32'd0);
         if (RValid0) begin
            if (q0.size() == 0) chk("rv0_unexpected", 32'(RValid0), 32'd0);
            else                chk("rdata0", 32'(RData), 32'(q0.pop_front()));
         end
         if (RValid1) begin
            if (q1.size() == 0) chk("rv1_unexpected", 32'(RValid1), 32'd0);
            else                chk("rdata1", 32'(RData), 32'(q1.pop_front()));
         end
         if (Gnt0 && Req0) begin
            if (Wr0) ref_mem[Addr0] = WData0;
            else     q0.push_back(ref_mem[Addr0]);
         end
         if (Gnt1 && Req1) q1.push_back(ref_mem[Addr1]);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0;
      Addr0 = '0; Addr1 = '0; WData0 = '0;
      step(); step();
      @(negedge Clock);
      chk("rst_gnt0", 32'(Gnt0), 32'd0);
      chk("rst_gnt1", 32'(Gnt1), 32'd0);
      chk("rst_rv0", 32'(RValid0), 32'd0);
      chk("rst_rv1", 32'(RValid1), 32'd0);
      chk("rst_wr", 32'(Mem_Write), 32'd0);
      chk("rst_addr", 32'(Mem_Addr), 32'd0);

      // Single load then read-back through port 1
      step(); Reset = 1'b0; Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 5'd5; WData0 = 8'h3C;
      @(negedge Clock); chk("load_gnt_latency", 32'(Gnt0), 32'd0);
      step();
      @(negedge Clock);
      chk("load_gnt0", 32'(Gnt0), 32'd1);
      chk("load_wr", 32'(Mem_Write), 32'd1);
      chk("load_addr", 32'(Mem_Addr), 32'd5);
      chk("load_din", 32'(Mem_DataIn), 32'h3C);
      step(); Req0 = 1'b0; Wr0 = 1'b0; Req1 = 1'b1; Addr1 = 5'd5;
      @(negedge Clock);
      chk("load_release_gnt1", 32'(Gnt1), 32'd0);
      chk("load_release_nowr", 32'(Mem_Write), 32'd0);
      step();
      @(negedge Clock);
      chk("rd_gnt1", 32'(Gnt1), 32'd1);
      chk("rd_addr", 32'(Mem_Addr), 32'd5);
      step(); Req1 = 1'b0;
      @(negedge Clock);
      chk("rd_rv1", 32'(RValid1), 32'd1);
      chk("rd_data", 32'(RData), 32'h3C);

      // Uncontended burst: port 0 writes addresses 0..9 without gaps
      step(); Req0 = 1'b1; Wr0 = 1'b1; Addr0 = '0; WData0 = 8'hA0;
      for (int i = 0; i < 10; i++) begin
         step(); Addr0 = 5'(i); WData0 = 8'(160 + i);
         @(negedge Clock);
         chk("burst_gnt0", 32'(Gnt0), 32'd1);
         chk("burst_wr", 32'(Mem_Write), 32'd1);
      end

      // Read pipeline: port 1 reads 0..3 back to back
      step(); Req0 = 1'b0; Wr0 = 1'b0; Req1 = 1'b1; Addr1 = '0;
      for (int k = 0; k < 4; k++) begin
         step(); Addr1 = 5'(k);
         @(negedge Clock);
         chk("pipe_gnt1", 32'(Gnt1), 32'd1);
         chk("pipe_rv1", 32'(RValid1), (k > 0) ? 32'd1 : 32'd0);
         chk("pipe_rv0", 32'(RValid0), 32'd0);
      end
      step(); Req1 = 1'b0;
      @(negedge Clock);
      chk("pipe_rv1_last", 32'(RValid1), 32'd1);
      chk("pipe_rdata_last", 32'(RData), 32'hA3);
      step();
      @(negedge Clock); chk("pipe_rv1_end", 32'(RValid1), 32'd0);

      // Early release: port 1 drops after 2 transactions while port 0 waits
      step(); Req1 = 1'b1; Addr1 = 5'd2;
      step(); Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 5'd3;
      @(negedge Clock); chk("er_gnt1_first", 32'(Gnt1), 32'd1);
      step();
      @(negedge Clock); chk("er_gnt1_second", 32'(Gnt1), 32'd1);
      step(); Req1 = 1'b0;
      @(negedge Clock); chk("er_gnt0_wait", 32'(Gnt0), 32'd0);
      step(); Req1 = 1'b1; Addr1 = 5'd4;
      @(negedge Clock); chk("er_gnt0", 32'(Gnt0), 32'd1);
      for (int j = 1; j <= 4; j++) begin
         step();
         @(negedge Clock);
         chk("er_seq_gnt0", 32'(Gnt0), (j < 4) ? 32'd1 : 32'd0);
         chk("er_seq_gnt1", 32'(Gnt1), (j == 4) ? 32'd1 : 32'd0);
      end
      step(); Req0 = 1'b0; Req1 = 1'b0;

      // Reset mid-stream, then a tie that must go to port 0 and alternate every MB cycles
      step(); Req1 = 1'b1; Addr1 = 5'd1;
      step(); Addr1 = 5'd2;
      step(); Addr1 = 5'd3;
      step(); Reset = 1'b1;
      step(); Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 5'd5; Addr1 = 5'd6;
      @(negedge Clock);
      chk("rst2_gnt0", 32'(Gnt0), 32'd0);
      chk("rst2_gnt1", 32'(Gnt1), 32'd0);
      chk("rst2_rv0", 32'(RValid0), 32'd0);
      chk("rst2_rv1", 32'(RValid1), 32'd0);
      chk("rst2_wr", 32'(Mem_Write), 32'd0);
      step(); Reset = 1'b0;
      @(negedge Clock);
      chk("tie_idle_gnt0", 32'(Gnt0), 32'd0);
      chk("tie_idle_gnt1", 32'(Gnt1), 32'd0);
      for (int j = 0; j < 16; j++) begin
         step();
         @(negedge Clock);
         chk("tie_gnt0", 32'(Gnt0), (((j / MB) % 2) == 0) ? 32'd1 : 32'd0);
         chk("tie_gnt1", 32'(Gnt1), (((j / MB) % 2) == 1) ? 32'd1 : 32'd0);
      end
      step(); Req0 = 1'b0; Req1 = 1'b0;
      step(); step();
      @(negedge Clock);
      chk("sb_drained", 32'(q0.size() + q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
